// File: rtl/smm_engine_arb.sv
// Round-robin arbiter and sequencer sharing one Strassen 2x2 matmul engine
// between NUM_REQ requesters, with a completion watchdog.
module smm_engine_arb #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 31,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               eng_done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [SEL_W-1:0]   sel,
    output logic               eng_load,
    output logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] err,
    output logic               busy,
    output logic [CNT_W-1:0]   txn_count
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GRANT = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4,
        ABORT = 3'd5
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [SEL_W-1:0]    sel_r, ptr_r, ptr_adv_s, win_s, idx_s;
    logic [TMR_W-1:0]    timer_r;
    logic [CNT_W-1:0]    txn_count_r;
    logic                found_s;
    logic [NUM_REQ-1:0]  sel_oh_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] s);
        onehot = NUM_REQ'(1) << s;
    endfunction

    // Round-robin scan starting at ptr; first set request wins.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = SEL_W'((int'(ptr_r) + i) % NUM_REQ);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                win_s   = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign ptr_adv_s = (sel_r == SEL_W'(NUM_REQ - 1)) ? SEL_W'(0) : sel_r + SEL_W'(1);
    assign sel_oh_s  = onehot(sel_r);

    // Next-state logic; completion wins over the watchdog on the same cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) state_nxt_s = GRANT;
                else         state_nxt_s = IDLE;
            end
            GRANT: state_nxt_s = START;
            START: state_nxt_s = WAIT;
            WAIT: begin
                if (eng_done)                          state_nxt_s = DONE;
                else if (timer_r == TMR_W'(TIMEOUT))   state_nxt_s = ABORT;
                else                                   state_nxt_s = WAIT;
            end
            DONE:    state_nxt_s = IDLE;
            ABORT:   state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, select, pointer, watchdog timer and transaction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            sel_r       <= '0;
            ptr_r       <= '0;
            timer_r     <= '0;
            txn_count_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                IDLE: begin
                    if (found_s) sel_r <= win_s;
                end
                START: timer_r <= '0;
                WAIT:  timer_r <= timer_r + TMR_W'(1);
                DONE: begin
                    txn_count_r <= txn_count_r + CNT_W'(1);
                    ptr_r       <= ptr_adv_s;
                end
                ABORT:   ptr_r <= ptr_adv_s;
                default: ;
            endcase
        end
    end

    // Moore output decode from the registered state and select.
    always_comb begin
        gnt      = '0;
        done     = '0;
        err      = '0;
        eng_load = 1'b0;
        busy     = 1'b1;
        case (state_r)
            IDLE:  busy = 1'b0;
            GRANT: gnt  = sel_oh_s;
            START: begin
                gnt      = sel_oh_s;
                eng_load = 1'b1;
            end
            WAIT:  gnt  = sel_oh_s;
            DONE: begin
                gnt  = sel_oh_s;
                done = sel_oh_s;
            end
            ABORT:   err  = sel_oh_s;
            default: busy = 1'b0;
        endcase
    end

    assign sel       = sel_r;
    assign txn_count = txn_count_r;

endmodule

// File: tb/tb_smm_engine_arb.sv
// Self-checking bench: transaction-timeline reference model with directed and
// randomized requests, engine latencies, spurious completions and resets.
module tb_smm_engine_arb;

    localparam int N  = 4;
    localparam int SW = 2;
    localparam int TO = 31;
    localparam int CW = 6;   // small counter so wrap-around is reached quickly

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          eng_done;
    logic [N-1:0]  gnt, done, err;
    logic [SW-1:0] sel;
    logic          eng_load, busy;
    logic [CW-1:0] txn_count;

    int            checks = 0;
    int            errors = 0;
    int            mptr   = 0;
    int            msel   = 0;
    logic [CW-1:0] mcount = '0;
    int            w;

    smm_engine_arb #(.NUM_REQ(N), .SEL_W(SW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .eng_done(eng_done),
        .gnt(gnt), .sel(sel), .eng_load(eng_load), .done(done), .err(err),
        .busy(busy), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: scan from p upward modulo N, first set bit wins.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    // Runs one transaction from an idle cycle. lat=0 means the engine never
    // answers; mode 1 scrambles req after grant, mode 2 drops req from cycle 3.
    task automatic run_txn(input logic [N-1:0] r, input int lat, input int mode, output int wo);
        int           end_c;
        logic [N-1:0] oh;
        wo    = pick(r, mptr);
        oh    = N'(1) << wo;
        end_c = (lat != 0) ? 3 + lat : 4 + TO;
        req = r;
        eng_done = 1'b0;
        @(posedge clk); #1;
        for (int c = 1; c <= end_c; c++) begin
            if (mode == 1)                req = N'($urandom);
            else if (mode == 2 && c >= 3) req = '0;
            if (lat != 0 && c == 2 + lat)      eng_done = 1'b1;
            else if (c <= 2 || c == end_c)     eng_done = 1'($urandom_range(0, 1));
            else                               eng_done = 1'b0;
            #4;
            check($sformatf("sel c%0d", c), 32'(sel), 32'(wo));
            check($sformatf("gnt c%0d", c), 32'(gnt), 32'((lat == 0 && c == end_c) ? '0 : oh));
            check($sformatf("eng_load c%0d", c), 32'(eng_load), 32'(c == 2));
            check($sformatf("done c%0d", c), 32'(done), 32'((lat != 0 && c == end_c) ? oh : '0));
            check($sformatf("err c%0d", c), 32'(err), 32'((lat == 0 && c == end_c) ? oh : '0));
            check($sformatf("busy c%0d", c), 32'(busy), 32'(1));
            @(posedge clk); #1;
        end
        eng_done = 1'b0;
        req      = '0;
        mptr     = (wo + 1) % N;
        msel     = wo;
        if (lat != 0) mcount = mcount + CW'(1);
        #4;
        check("busy after", 32'(busy), 32'(0));
        check("gnt after", 32'(gnt), 32'(0));
        check("txn_count", 32'(txn_count), 32'(mcount));
    endtask

    // Idle cycles with random eng_done noise: nothing may move.
    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            req      = '0;
            eng_done = 1'($urandom_range(0, 1));
            @(posedge clk); #5;
            check("idle busy", 32'(busy), 32'(0));
            check("idle outs", 32'({gnt, done, err, eng_load}), 32'(0));
            check("idle sel", 32'(sel), 32'(msel));
            check("idle count", 32'(txn_count), 32'(mcount));
        end
        eng_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        eng_done = 1'b0;
        repeat (3) @(posedge clk);
        #5;
        check("rst outs", 32'({gnt, done, err, eng_load, busy}), 32'(0));
        check("rst sel", 32'(sel), 32'(0));
        check("rst count", 32'(txn_count), 32'(0));
        rst = 1'b0;

        // Fairness: all requesting from reset -> 0,1,2,3,0,1
        for (int i = 0; i < 6; i++) run_txn(4'b1111, 9, 0, w);

        // Single requester with nominal engine latency
        run_txn(4'b0100, 9, 0, w);

        // Watchdog abort, then pointer must sit just past the aborted index
        run_txn(4'b0010, 0, 0, w);
        run_txn(4'b1111, 9, 0, w);

        // Completion on the very cycle the watchdog expires
        run_txn(4'b1111, TO + 1, 0, w);

        // Reset in the middle of WAIT
        req = 4'b0100;
        @(posedge clk); #1;
        req = '0;
        repeat (3) @(posedge clk);
        #4;
        check("mid sel", 32'(sel), 32'(2));
        check("mid busy", 32'(busy), 32'(1));
        rst = 1'b1;
        @(posedge clk); #5;
        check("mid rst outs", 32'({gnt, done, err, eng_load, busy}), 32'(0));
        check("mid rst sel", 32'(sel), 32'(0));
        check("mid rst count", 32'(txn_count), 32'(0));
        rst    = 1'b0;
        mptr   = 0;
        msel   = 0;
        mcount = '0;
        run_txn(4'b1010, 9, 0, w);

        // Spurious completions while idle, then a dropped request
        idle_cycles(5);
        run_txn(4'b0001, 9, 2, w);

        // Randomized traffic, long enough for the counter to wrap
        for (int i = 0; i < 90; i++) begin
            logic [N-1:0] r;
            int           lat;
            r   = N'($urandom_range(1, (1 << N) - 1));
            lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO + 1));
            run_txn(r, lat, int'($urandom_range(0, 2)), w);
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
